// File: rtl/nubus_video_pkg.sv
// +-----------------------------------------------------------------------+
// | nubus_video_pkg                                                       |
// | Shared types and constants for the NuBus video card datapath.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package nubus_video_pkg;

  localparam int VRAM_ADDR_W        = 25;
  localparam int LINE_WORDS_DEFAULT = 320;
  localparam int LINES_DEFAULT      = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } scanout_state_t;

endpackage

`default_nettype wire

// File: rtl/nubus_sync_fifo.sv
// +-----------------------------------------------------------------------+
// | nubus_sync_fifo                                                       |
// | Show-ahead synchronous FIFO with registered head word and level.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module nubus_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_head;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [LVL_W-1:0] w_level_pop;
  logic [LVL_W-1:0] w_level_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  always_comb begin
    w_pop        = pop && (r_level != '0);
    w_push       = push && ((r_level != LVL_W'(DEPTH)) || w_pop);
    w_rd_ptr_nxt = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_level_pop  = w_pop ? r_level - LVL_W'(1) : r_level;
    w_level_nxt  = w_push ? w_level_pop + LVL_W'(1) : w_level_pop;
    // The incoming word bypasses memory when it becomes the new head
    if (w_level_nxt == '0)
      w_head_nxt = '0;
    else if (w_level_pop == '0)
      w_head_nxt = din;
    else
      w_head_nxt = r_mem[w_rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush)
      r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_head   <= w_head_nxt;
    end
  end

  assign dout  = r_head;
  assign valid = (r_level != '0);
  assign level = r_level;

endmodule

`default_nettype wire

// File: rtl/nubus_vram_scanout.sv
// +-----------------------------------------------------------------------+
// | nubus_vram_scanout                                                    |
// | Frame-buffer scanout prefetcher feeding the pixel serialiser FIFO.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module nubus_vram_scanout
  import nubus_video_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int LINES      = LINES_DEFAULT,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       stride,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  input  logic [15:0]       vram_din,
  input  logic              vram_ready,
  input  logic              pix_pop,
  output logic [15:0]       pix_word,
  output logic              pix_valid,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              underrun,
  output logic              frame_done
);

  localparam int c_WC_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int c_LC_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [c_WC_W-1:0] c_LAST_WORD = c_WC_W'(LINE_WORDS - 1);
  localparam logic [c_LC_W-1:0] c_LAST_LINE = c_LC_W'(LINES - 1);

  scanout_state_t      r_state;
  scanout_state_t      w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_line_base;
  logic [15:0]         r_stride;
  logic [c_WC_W-1:0]   r_word_cnt;
  logic [c_LC_W-1:0]   r_line_cnt;
  logic                r_all_fetched;
  logic                r_underrun;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_next_line;

  // A ready coinciding with frame_start belongs to the old frame and is dropped
  assign w_accept    = (r_state == REQ) && vram_ready && !frame_start;
  assign w_next_line = r_line_base + ADDR_W'(r_stride);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: w_state_nxt = IDLE;
      REQ:  if (vram_ready) w_state_nxt = GAP;
      GAP: begin
        if (r_all_fetched)
          w_state_nxt = DONE;
        else if (fifo_level < LVL_W'(FIFO_DEPTH))
          w_state_nxt = REQ;
      end
      DONE: w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (frame_start)
      w_state_nxt = GAP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr        <= '0;
      r_line_base   <= '0;
      r_stride      <= '0;
      r_word_cnt    <= '0;
      r_line_cnt    <= '0;
      r_all_fetched <= 1'b0;
    end else if (frame_start) begin
      r_addr        <= base_addr;
      r_line_base   <= base_addr;
      r_stride      <= stride;
      r_word_cnt    <= '0;
      r_line_cnt    <= '0;
      r_all_fetched <= 1'b0;
    end else if (w_accept) begin
      if (r_word_cnt == c_LAST_WORD) begin
        r_word_cnt  <= '0;
        r_line_base <= w_next_line;
        r_addr      <= w_next_line;
        r_line_cnt  <= r_line_cnt + c_LC_W'(1);
        if (r_line_cnt == c_LAST_LINE)
          r_all_fetched <= 1'b1;
      end else begin
        r_word_cnt <= r_word_cnt + c_WC_W'(1);
        r_addr     <= r_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_underrun <= 1'b0;
    else if (frame_start)
      r_underrun <= 1'b0;
    else if (pix_pop && (fifo_level == '0))
      r_underrun <= 1'b1;
  end

  nubus_sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (frame_start),
    .push  (w_accept),
    .din   (vram_din),
    .pop   (pix_pop),
    .dout  (pix_word),
    .valid (pix_valid),
    .level (fifo_level)
  );

  assign vram_addr  = r_addr;
  assign vram_rd    = (r_state == REQ);
  assign frame_done = (r_state == DONE);
  assign underrun   = r_underrun;

endmodule

`default_nettype wire
